// File: rtl/scan_decoder_h.sv
// scan_decoder_h: registered N-to-2^N decoder with active-low enable/outputs and an auto-scan mode
//   CLK   : system clock, rising edge
//   RST_L : asynchronous active-low reset
//   G_L   : active-low enable; 1 forces Y to all ones
//   MODE  : 0 = direct decode of SEL, 1 = auto-scan
//   SEL   : direct-mode select
//   DWELL : scan dwell; each output is held DWELL+1 cycles
//   Y     : active-low decoded outputs (registered)
//   IDX   : index of the active output (registered)
//   WRAP  : one-cycle pulse when the scan index wraps to 0
module scan_decoder_h #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_L,
  input  logic                 G_L,
  input  logic                 MODE,
  input  logic [SEL_W-1:0]     SEL,
  input  logic [DWELL_W-1:0]   DWELL,
  output logic [2**SEL_W-1:0]  Y,
  output logic [SEL_W-1:0]     IDX,
  output logic                 WRAP
);
  localparam int N = 2**SEL_W;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] idx_nx;
  logic [N-1:0] y_nx;
  logic wrap_nx, stay, adv;
  always_comb begin
    state_nx = G_L ? IDLE : (MODE ? SCAN : DIRECT);
    stay     = state == SCAN && state_nx == SCAN;
    // >= lets a lowered DWELL take effect on the very next edge
    adv      = stay && cnt >= DWELL;
    idx_nx   = state_nx == DIRECT ? SEL : adv ? SEL_W'(IDX + 1'b1) : stay ? IDX : '0;
    cnt_nx   = stay && !adv ? DWELL_W'(cnt + 1'b1) : '0;
    wrap_nx  = adv && &IDX;
    y_nx     = state_nx == IDLE ? '1 : ~(N'(1) << idx_nx);
  end
  always_ff @(posedge CLK or negedge RST_L)
    if (!RST_L) begin
      state <= IDLE;
      cnt   <= '0;
      IDX   <= '0;
      Y     <= '1;
      WRAP  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      IDX   <= idx_nx;
      Y     <= y_nx;
      WRAP  <= wrap_nx;
    end
endmodule

// File: tb/tb_scan_decoder_h.sv
// tb_scan_decoder_h: directed self-checking bench for scan_decoder_h (SEL_W=2)
module tb_scan_decoder_h;
  logic CLK = 1'b0;
  logic RST_L, G_L, MODE;
  logic [1:0] SEL;
  logic [7:0] DWELL;
  logic [3:0] Y;
  logic [1:0] IDX;
  logic WRAP;
  int checks = 0;
  int errors = 0;

  scan_decoder_h #(.SEL_W(2), .DWELL_W(8)) dut (
    .CLK(CLK), .RST_L(RST_L), .G_L(G_L), .MODE(MODE), .SEL(SEL),
    .DWELL(DWELL), .Y(Y), .IDX(IDX), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] y, input logic [1:0] i, input logic w);
    chk({tag, "_y"}, 32'(Y), 32'(y));
    chk({tag, "_idx"}, 32'(IDX), 32'(i));
    chk({tag, "_wrap"}, 32'(WRAP), 32'(w));
  endtask

  logic [3:0] sc_y [14] = '{4'hE, 4'hE, 4'hE, 4'hD, 4'hD, 4'hD, 4'hB, 4'hB, 4'hB,
                            4'h7, 4'h7, 4'h7, 4'hE, 4'hE};
  logic [1:0] sc_i [14] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
  logic       sc_w [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [3:0] dr_y [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [3:0] d0_y [5]  = '{4'hD, 4'hB, 4'h7, 4'hE, 4'hD};
  logic [1:0] d0_i [5]  = '{1, 2, 3, 0, 1};
  logic       d0_w [5]  = '{0, 0, 0, 1, 0};

  initial begin
    RST_L = 1'b0; G_L = 1'b0; MODE = 1'b1; SEL = 2'd0; DWELL = 8'd2;
    tick(); tick();
    chk3("reset", 4'hF, 2'd0, 1'b0);
    RST_L = 1'b1;
    #3;
    chk3("release_hold", 4'hF, 2'd0, 1'b0);
    MODE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      tick();
      chk3($sformatf("direct%0d", s), dr_y[s], 2'(s), 1'b0);
    end
    G_L = 1'b1;
    tick();
    chk3("disable", 4'hF, 2'd0, 1'b0);
    G_L = 1'b0; MODE = 1'b1; DWELL = 8'd2;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk3($sformatf("scan2_%0d", k), sc_y[k], sc_i[k], sc_w[k]);
    end
    DWELL = 8'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk3($sformatf("scan0_%0d", k), d0_y[k], d0_i[k], d0_w[k]);
    end
    DWELL = 8'd5;
    tick(); tick(); tick();
    chk3("dwell5_hold", 4'hD, 2'd1, 1'b0);
    DWELL = 8'd1;
    tick();
    chk3("dwell_lowered", 4'hB, 2'd2, 1'b0);
    MODE = 1'b0; SEL = 2'd1;
    tick();
    chk3("scan_to_direct", 4'hD, 2'd1, 1'b0);
    MODE = 1'b1;
    tick();
    chk3("direct_to_scan", 4'hE, 2'd0, 1'b0);
    tick();
    chk3("d1_cnt", 4'hE, 2'd0, 1'b0);
    tick();
    chk3("d1_adv1", 4'hD, 2'd1, 1'b0);
    tick(); tick();
    chk3("d1_adv2", 4'hB, 2'd2, 1'b0);
    G_L = 1'b1;
    tick();
    chk3("idle_mid", 4'hF, 2'd0, 1'b0);
    G_L = 1'b0;
    tick();
    chk3("reenable", 4'hE, 2'd0, 1'b0);
    for (int k = 0; k < 6; k++) tick();
    chk3("at_idx3", 4'h7, 2'd3, 1'b0);
    #2 RST_L = 1'b0;
    #1;
    chk3("async_reset", 4'hF, 2'd0, 1'b0);
    #1 RST_L = 1'b1;
    #1;
    chk3("async_release", 4'hF, 2'd0, 1'b0);
    tick();
    chk3("post_reset_scan", 4'hE, 2'd0, 1'b0);
    tick(); tick();
    chk3("post_reset_adv", 4'hD, 2'd1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
